mem_port_arbiter: RTL and testbench

Arbitrates one shared single-ported memory between the instruction-fetch requester (F) and the load/store data requester (D) of the multicycle core. Data accesses have priority. A starvation counter forces a fetch grant after a bounded run of data grants. Each accepted request becomes one req/ack transaction on the memory side, with a timeout watchdog.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Fetch, data and memory-side bus bundle for mem_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_valid;
  logic [DATA_W-1:0] f_rdata;

  logic                f_unused_dummy;
  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_valid;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic                m_ack;
  logic [DATA_W-1:0]   m_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
    output f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_be
  );

  // Requester and memory side
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
    input  f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Data-priority arbiter for a shared single-ported memory, with
//          fetch anti-starvation and an ack timeout watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_F = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIMIT);
  localparam logic [7:0] c_wd_last    = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                f_gnt_q, f_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                f_valid_q, f_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_be_q, m_be_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic [7:0]          wd_cnt_q, wd_cnt_d;
  logic                d_wins;

  // Data has priority unless fetch has already waited through STARVE_LIMIT data grants
  assign d_wins = bus.d_req && !(bus.f_req && (starve_cnt_q == c_starve_lim));

  always_comb begin
    state_d      = state_q;
    f_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    f_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    busy_d       = busy_q;
    err_d        = err_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (d_wins) begin
          state_d   = ST_BUSY_D;
          d_gnt_d   = 1'b1;
          m_req_d   = 1'b1;
          busy_d    = 1'b1;
          m_we_d    = bus.d_we;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_be_d    = bus.d_be;
          wd_cnt_d  = 8'd0;
          if (!bus.f_req) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q != c_starve_lim) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (bus.f_req) begin
          state_d      = ST_BUSY_F;
          f_gnt_d      = 1'b1;
          m_req_d      = 1'b1;
          busy_d       = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = bus.f_addr;
          m_wdata_d    = '0;
          m_be_d       = '1;
          wd_cnt_d     = 8'd0;
          starve_cnt_d = 4'd0;
        end
      end

      ST_BUSY_F, ST_BUSY_D: begin
        // An ack arriving in the final watchdog cycle still completes normally
        if (bus.m_ack) begin
          state_d = ST_IDLE;
          m_req_d = 1'b0;
          busy_d  = 1'b0;
          if (state_q == ST_BUSY_F) begin
            f_valid_d = 1'b1;
            f_rdata_d = bus.m_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = bus.m_rdata;
            end
          end
        end else if (wd_cnt_q == c_wd_last) begin
          state_d = ST_IDLE;
          m_req_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          if (state_q == ST_BUSY_F) begin
            f_valid_d = 1'b1;
            f_rdata_d = '0;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        m_req_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      f_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      f_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt_q <= 4'd0;
      wd_cnt_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      f_gnt_q      <= f_gnt_d;
      d_gnt_q      <= d_gnt_d;
      f_valid_q    <= f_valid_d;
      d_valid_q    <= d_valid_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign bus.f_gnt   = f_gnt_q;
  assign bus.d_gnt   = d_gnt_q;
  assign bus.f_valid = f_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.f_rdata = f_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_be    = m_be_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Scenario bench for mem_port_arbiter with a valid-pulse scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic err;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_f;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] d_rdata_m   = '0;
  logic        err_m       = 1'b0;

  task automatic step();
    @(negedge clk);
  endtask

  // Queue the expected completion; loads and aborts also update the rdata model
  task automatic push_exp(bit is_f, logic [31:0] rd, bit is_read, logic e);
    exp_t x;
    x.is_f = is_f;
    if (!is_f && !is_read) x.rdata = d_rdata_m;
    else x.rdata = rd;
    if (!is_f && is_read) d_rdata_m = rd;
    x.err = e;
    sb.push_back(x);
  endtask

  // Valid-pulse scoreboard and bus invariants
  initial begin
    logic        prev_req;
    logic [70:0] prev_fields;
    exp_t        e;
    prev_req    = 1'b0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_req = 1'b0;
      end else begin
        vectors++;
        if ((bus.f_gnt && bus.d_gnt) || (bus.f_valid && bus.d_valid)) begin
          miscompares++;
          $display("FAIL exclusive: gnt=%b%b valid=%b%b, required at most one of each",
                   bus.f_gnt, bus.d_gnt, bus.f_valid, bus.d_valid);
        end
        if (prev_req && bus.m_req) begin
          vectors++;
          if ({bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !== prev_fields) begin
            miscompares++;
            $display("FAIL m_stable: got %h required %h",
                     {bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata}, prev_fields);
          end
        end
        if (bus.f_valid || bus.d_valid) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected_valid: f_valid=%b d_valid=%b, required none",
                     bus.f_valid, bus.d_valid);
          end else begin
            e = sb.pop_front();
            if (bus.f_valid !== e.is_f ||
                (e.is_f ? bus.f_rdata : bus.d_rdata) !== e.rdata || err !== e.err) begin
              miscompares++;
              $display("FAIL sb_completion: got f=%b rdata=%h err=%b required f=%b rdata=%h err=%b",
                       bus.f_valid, (e.is_f ? bus.f_rdata : bus.d_rdata), err,
                       e.is_f, e.rdata, e.err);
            end
          end
        end
        prev_req    = bus.m_req;
        prev_fields = {bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata};
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    bus.f_req = 0; bus.f_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.m_ack = 0; bus.m_rdata = '0;
    step();
    vectors++;
    if ({busy, err, bus.m_req, bus.f_gnt, bus.d_gnt, bus.f_valid, bus.d_valid} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, err, bus.m_req, bus.f_gnt, bus.d_gnt, bus.f_valid, bus.d_valid});
    end
    vectors++;
    if ({bus.m_addr, bus.f_rdata, bus.d_rdata} !== 96'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {bus.m_addr, bus.f_rdata, bus.d_rdata});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_load();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    step();
    vectors++;
    if ({bus.d_gnt, bus.m_req, bus.f_gnt, busy, bus.m_we} !== 5'b11010 || bus.m_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL load_gnt: got gnt/req/fgnt/busy/we=%b addr=%h required 11010 addr=100",
               {bus.d_gnt, bus.m_req, bus.f_gnt, busy, bus.m_we}, bus.m_addr);
    end
    bus.d_req = 0;
    step();
    vectors++;
    if ({bus.d_gnt, bus.m_req} !== 2'b01) begin
      miscompares++;
      $display("FAIL load_hold: got gnt/req=%b required 01", {bus.d_gnt, bus.m_req});
    end
    step();
    bus.m_ack = 1; bus.m_rdata = 32'hCAFEF00D;
    push_exp(0, 32'hCAFEF00D, 1, err_m);
    step();
    bus.m_ack = 0;
    vectors++;
    if ({bus.d_valid, bus.m_req, busy, bus.f_valid} !== 4'b1000 || bus.d_rdata !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL load_done: got valid/req/busy/fvalid=%b rdata=%h required 1000 cafef00d",
               {bus.d_valid, bus.m_req, busy, bus.f_valid}, bus.d_rdata);
    end
    step();
  endtask

  task automatic test_store();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200;
    bus.d_be = 4'b0011; bus.d_wdata = 32'h1234ABCD;
    step();
    bus.d_req = 0; bus.d_we = 0; bus.d_wdata = '0; bus.d_be = '0;
    vectors++;
    if ({bus.m_we, bus.m_be} !== 5'b10011 || bus.m_wdata !== 32'h1234ABCD) begin
      miscompares++;
      $display("FAIL store_fields: got we/be=%b wdata=%h required 10011 1234abcd",
               {bus.m_we, bus.m_be}, bus.m_wdata);
    end
    step();
    step();
    bus.m_ack = 1; bus.m_rdata = 32'hDEADBEEF;
    push_exp(0, 32'h0, 0, err_m);
    step();
    bus.m_ack = 0;
    vectors++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL store_done: got valid=%b rdata=%h required 1 cafef00d",
               bus.d_valid, bus.d_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    bit         found;
    logic [3:0] s;
    bus.f_req = 1; bus.f_addr = 32'h800;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h900;
    for (int g = 0; g < 10; g++) begin
      found = 0;
      s = '0;
      for (int w = 0; w < 6 && !found; w++) begin
        s = dut.starve_cnt_q;
        step();
        if (bus.f_gnt || bus.d_gnt) found = 1;
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL starve_gnt_timeout: grant %0d got none required a grant", g);
      end else begin
        if (bus.f_gnt !== (g == 4 || g == 9)) begin
          miscompares++;
          $display("FAIL starve_order: grant %0d got f_gnt=%b required %b",
                   g, bus.f_gnt, (g == 4 || g == 9));
        end
        if (g == 4 || g == 9) begin
          vectors++;
          if (s !== 4'd4) begin
            miscompares++;
            $display("FAIL starve_cnt: grant %0d got %0d required 4", g, s);
          end
        end
      end
      if (g == 9) begin
        bus.f_req = 0; bus.d_req = 0;
      end
      step();
      bus.m_ack = 1; bus.m_rdata = 32'hA000_0000 + 32'(g);
      push_exp(g == 4 || g == 9, 32'hA000_0000 + 32'(g), 1, err_m);
      step();
      bus.m_ack = 0;
    end
    step();
  endtask

  task automatic test_ack_timeout_race();
    bus.f_req = 1; bus.f_addr = 32'h700;
    step();
    bus.f_req = 0;
    repeat (7) step();
    vectors++;
    if (bus.m_req !== 1'b1) begin
      miscompares++;
      $display("FAIL race_req: got m_req=%b in 8th cycle required 1", bus.m_req);
    end
    bus.m_ack = 1; bus.m_rdata = 32'h7777_1111;
    push_exp(1, 32'h7777_1111, 1, 1'b0);
    step();
    bus.m_ack = 0;
    vectors++;
    if ({bus.f_valid, err} !== 2'b10 || bus.f_rdata !== 32'h7777_1111) begin
      miscompares++;
      $display("FAIL race_done: got valid/err=%b rdata=%h required 10 77771111",
               {bus.f_valid, err}, bus.f_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    int cnt;
    bus.f_req = 1; bus.f_addr = 32'h300;
    step();
    bus.f_req = 0;
    vectors++;
    if (bus.f_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL to_gnt: got f_gnt=%b required 1", bus.f_gnt);
    end
    push_exp(1, 32'h0, 1, 1'b1);
    cnt = 1;
    for (int w = 0; w < 20; w++) begin
      step();
      if (bus.m_req) cnt++;
      else break;
    end
    vectors++;
    if (cnt !== 8) begin
      miscompares++;
      $display("FAIL to_len: got %0d m_req cycles required 8", cnt);
    end
    vectors++;
    if ({bus.f_valid, err} !== 2'b11 || bus.f_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL to_abort: got valid/err=%b rdata=%h required 11 0",
               {bus.f_valid, err}, bus.f_rdata);
    end
    err_m = 1'b1;
    step();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
    step();
    bus.d_req = 0;
    bus.m_ack = 1; bus.m_rdata = 32'h5555AAAA;
    push_exp(0, 32'h5555AAAA, 1, err_m);
    step();
    bus.m_ack = 0;
    vectors++;
    if ({bus.d_valid, err} !== 2'b11) begin
      miscompares++;
      $display("FAIL err_sticky: got valid/err=%b required 11", {bus.d_valid, err});
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
    step();
    bus.d_req = 0;
    step();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({bus.m_req, busy, bus.d_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_async: got req/busy/valid=%b required 000",
               {bus.m_req, busy, bus.d_valid});
    end
    step();
    reset = 1'b1;
    err_m = 1'b0;
    d_rdata_m = '0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_err: got err=%b required 0", err);
    end
    bus.f_req = 1; bus.f_addr = 32'h600;
    step();
    bus.f_req = 0;
    vectors++;
    if (bus.f_gnt !== 1'b1 || dut.starve_cnt_q !== 4'd0 || bus.m_addr !== 32'h600) begin
      miscompares++;
      $display("FAIL rst_regrant: got f_gnt=%b starve=%0d addr=%h required 1 0 600",
               bus.f_gnt, dut.starve_cnt_q, bus.m_addr);
    end
    bus.m_ack = 1; bus.m_rdata = 32'h0BADF00D;
    push_exp(1, 32'h0BADF00D, 1, err_m);
    step();
    bus.m_ack = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_starvation();
    test_ack_timeout_race();
    test_timeout();
    test_reset_mid();
    step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending completions required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "bench time limit reached");
  end

endmodule

`default_nettype wire
